// File: rtl/mac_requant.sv
// mac_requant: tracks valid MAC-chain samples, rounds and shifts the 48-bit accumulator,
// saturates to OUT_W bits and buffers results in a credit-protected output FIFO.
`default_nettype none

module mac_requant #(
  parameter int LATENCY = 6,
  parameter int SHIFT   = 14,
  parameter int OUT_W   = 8,
  parameter int DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [47:0]      p,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_data,
  output logic [15:0]             sat_cnt
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [48:0] RND  = (SHIFT > 0) ? (49'sd1 <<< RSH) : 49'sd0;
  localparam logic signed [48:0] QMAX = (49'sd1 <<< (OUT_W - 1)) - 49'sd1;
  localparam logic signed [48:0] QMIN = -(49'sd1 <<< (OUT_W - 1));
  localparam logic [OUT_W-1:0]   OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]   OMIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [LATENCY-1:0]       vpipe;
  logic                     accept;
  logic                     pop;
  logic                     r_valid;
  logic signed [48:0]       r;
  logic signed [48:0]       q;
  logic                     q_hi;
  logic                     q_lo;
  logic                     s_valid;
  logic signed [OUT_W-1:0]  s_data;
  logic [CW-1:0]            cred;
  logic [CW-1:0]            count;
  logic [PW-1:0]            wptr;
  logic [PW-1:0]            rptr;
  logic signed [OUT_W-1:0]  mem [DEPTH];

  assign accept   = in_valid & in_ready;
  assign in_ready = cred < CW'(DEPTH);
  assign m_valid  = count != '0;
  assign pop      = m_valid & m_ready;
  assign m_data   = m_valid ? mem[rptr] : '0;

  assign q    = r >>> SHIFT;
  assign q_hi = q > QMAX;
  assign q_lo = q < QMIN;

  // One bit per accepted sample; the top bit marks the cycle its p arrives.
  generate
    if (LATENCY > 1) begin : g_vpipe_multi
      always_ff @(posedge clk) begin
        if (rst) vpipe <= '0;
        else     vpipe <= {vpipe[LATENCY-2:0], accept};
      end
    end else begin : g_vpipe_single
      always_ff @(posedge clk) begin
        if (rst) vpipe <= '0;
        else     vpipe <= accept;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r       <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      sat_cnt <= '0;
    end else begin
      r_valid <= vpipe[LATENCY-1];
      if (vpipe[LATENCY-1]) r <= {p[47], p} + RND;
      s_valid <= r_valid;
      if (r_valid) begin
        s_data <= q_hi ? OMAX : (q_lo ? OMIN : q[OUT_W-1:0]);
        if ((q_hi | q_lo) && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
      end
    end
  end

  // Storage needs no reset: m_data is gated by m_valid.
  always_ff @(posedge clk) begin
    if (s_valid) mem[wptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      cred  <= '0;
    end else begin
      if (s_valid) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({s_valid, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({accept, pop})
        2'b10:   cred <= cred + 1'b1;
        2'b01:   cred <= cred - 1'b1;
        default: cred <= cred;
      endcase
    end
  end

endmodule

`default_nettype wire
